// File: rtl/sram_mem_requester.sv
// CPU-side requester for the SRAM controller handshake.
// Stores are posted into a small write buffer and drained in order; loads that hit
// a buffered store are forwarded with no SRAM access, load misses freeze the pipeline
// until the controller returns data.
module sram_mem_requester #(
    parameter int unsigned WB_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        freeze,
    output logic        sram_wr_en,
    output logic        sram_rd_en,
    output logic [31:0] sram_address,
    output logic [31:0] sram_writeData,
    input  logic [31:0] sram_readData,
    input  logic        sram_ready
);

    localparam int unsigned PtrW = $clog2(WB_DEPTH);
    localparam int unsigned CntW = $clog2(WB_DEPTH + 1);
    localparam logic [CntW-1:0] WbFull = CntW'(WB_DEPTH);

    typedef enum logic [1:0] {StIdle, StWr, StRd, StResp} state_e;

    state_e state_q, state_d;

    // Write buffer storage and bookkeeping
    logic [31:0]     wb_addr_q [WB_DEPTH];
    logic [31:0]     wb_data_q [WB_DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q, count_d;

    // Registered request outputs and captured load data
    logic        wr_en_q, wr_en_d;
    logic        rd_en_q, rd_en_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic        rd_req;
    logic        push;
    logic        pop;
    logic        buf_empty;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic [PtrW-1:0] fwd_idx;

    // A simultaneous load and store is treated as a store only
    assign rd_req    = mem_r_en && !mem_w_en;
    assign buf_empty = (count_q == '0);
    // Full is judged on the registered count, so a same-cycle pop never frees a slot early
    assign push      = mem_w_en && (count_q != WbFull);
    assign pop       = (state_q == StWr) && sram_ready;

    // Occupancy next-state
    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Write buffer: circular FIFO, push at tail, pop at head on drain completion
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wb_addr_q[wr_ptr_q] <= mem_addr;
                wb_data_q[wr_ptr_q] <= mem_wdata;
                wr_ptr_q            <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // Store-to-load forwarding: scan oldest to newest so the newest match wins;
    // the head entry being drained remains valid until its pop
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int unsigned i = 0; i < WB_DEPTH; i++) begin
            fwd_idx = rd_ptr_q + PtrW'(i);
            if (rd_req && (CntW'(i) < count_q) &&
                (wb_addr_q[fwd_idx][31:2] == mem_addr[31:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = wb_data_q[fwd_idx];
            end
        end
    end

    assign mem_rdata = fwd_hit ? fwd_data : rdata_q;
    assign freeze    = (mem_w_en && (count_q == WbFull)) ||
                       (rd_req && !fwd_hit && (state_q != StResp));

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: buffered (or arriving) stores always drain before a load miss
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (!buf_empty || push) begin
                    state_d = StWr;
                end else if (rd_req && !fwd_hit) begin
                    state_d = StRd;
                end
            end
            StWr: begin
                if (sram_ready) state_d = StIdle;
            end
            StRd: begin
                if (sram_ready) state_d = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: next values for the registered request signals
    always_comb begin
        wr_en_d = 1'b0;
        rd_en_d = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (!buf_empty) begin
                    wr_en_d = 1'b1;
                    addr_d  = wb_addr_q[rd_ptr_q];
                    wdata_d = wb_data_q[rd_ptr_q];
                end else if (push) begin
                    // Empty buffer: the arriving store becomes the head, issue it directly
                    wr_en_d = 1'b1;
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                end else if (rd_req && !fwd_hit) begin
                    rd_en_d = 1'b1;
                    addr_d  = mem_addr;
                end
            end
            StWr: begin
                wr_en_d = !sram_ready;
            end
            StRd: begin
                rd_en_d = !sram_ready;
                if (sram_ready) rdata_d = sram_readData;
            end
            StResp: begin
                wr_en_d = 1'b0;
                rd_en_d = 1'b0;
            end
            default: begin
                wr_en_d = 1'b0;
                rd_en_d = 1'b0;
            end
        endcase
    end

    // Request and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            wr_en_q <= wr_en_d;
            rd_en_q <= rd_en_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign sram_wr_en     = wr_en_q;
    assign sram_rd_en     = rd_en_q;
    assign sram_address   = addr_q;
    assign sram_writeData = wdata_q;

endmodule
